// File: rtl/calculus_unit_pipe_if.sv
// Handshake and data bundle between the SIMD operand-read stage, the calculus
// unit and writeback. The master side is upstream/downstream; the slave side is the unit.
interface calculus_unit_pipe_if #(
  parameter int FUNCTION_BITS = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int LANES         = 4
);
  logic [FUNCTION_BITS-1:0]   fn;
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*BIT_WIDTH-1:0] data_in0;
  logic [LANES*BIT_WIDTH-1:0] data_in1;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*BIT_WIDTH-1:0] data_out;
  logic                       busy;

  modport master (
    output fn, in_valid, data_in0, data_in1, out_ready,
    input  in_ready, out_valid, data_out, busy
  );

  modport slave (
    input  fn, in_valid, data_in0, data_in1, out_ready,
    output in_ready, out_valid, data_out, busy
  );
endinterface

// File: rtl/calculus_unit_pipe.sv
// Multi-lane elementwise calculus unit: single-cycle ReLU/MAX/ABS/SIGN and an
// iterative restoring integer square root, with valid/ready on both sides.
module calculus_unit_pipe #(
  parameter int FUNCTION_BITS = 4,
  parameter int BIT_WIDTH     = 32,
  parameter int LANES         = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  calculus_unit_pipe_if.slave     bus
);

  localparam int H  = BIT_WIDTH / 2;
  localparam int CW = $clog2(H + 1);
  localparam int DW = LANES * BIT_WIDTH;

  localparam logic [FUNCTION_BITS-1:0] FN_RELU = FUNCTION_BITS'(4'b0000);
  localparam logic [FUNCTION_BITS-1:0] FN_MAX  = FUNCTION_BITS'(4'b0001);
  localparam logic [FUNCTION_BITS-1:0] FN_ABS  = FUNCTION_BITS'(4'b0010);
  localparam logic [FUNCTION_BITS-1:0] FN_SIGN = FUNCTION_BITS'(4'b0011);
  localparam logic [FUNCTION_BITS-1:0] FN_SQRT = FUNCTION_BITS'(4'b1000);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]  rad_q  [LANES];
  logic [BIT_WIDTH-1:0]  rad_d  [LANES];
  logic [BIT_WIDTH-1:0]  rad_n  [LANES];
  logic [H+1:0]          rem_q  [LANES];
  logic [H+1:0]          rem_d  [LANES];
  logic [H+1:0]          rem_n  [LANES];
  logic [H-1:0]          root_q [LANES];
  logic [H-1:0]          root_d [LANES];
  logic [H-1:0]          root_n [LANES];
  logic [DW-1:0]         dout_q, dout_d;
  logic [DW-1:0]         single_res;
  logic [DW-1:0]         sqrt_res;
  logic                  in_ready;
  logic                  accept;

  function automatic logic [BIT_WIDTH-1:0] lane_op(
    input logic [FUNCTION_BITS-1:0]   f,
    input logic signed [BIT_WIDTH-1:0] x,
    input logic signed [BIT_WIDTH-1:0] y
  );
    logic [BIT_WIDTH-1:0] r;
    logic [BIT_WIDTH-1:0] most_neg;
    most_neg = {1'b1, {(BIT_WIDTH-1){1'b0}}};
    r = '0;
    case (f)
      FN_RELU: r = x[BIT_WIDTH-1] ? '0 : x;
      FN_MAX:  r = (x > y) ? x : y;
      FN_ABS: begin
        if (x == most_neg)      r = ~most_neg;
        else if (x[BIT_WIDTH-1]) r = -x;
        else                     r = x;
      end
      FN_SIGN: begin
        if (x == '0)             r = '0;
        else if (x[BIT_WIDTH-1]) r = '1;
        else                     r = BIT_WIDTH'(1);
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // One restoring step per lane: try subtracting (root<<2 | 1) from the
  // remainder extended by the next two radicand bits; keep it only if non-negative.
  always_comb begin
    logic [H+1:0] shifted;
    logic [H+2:0] diff;
    single_res = '0;
    sqrt_res   = '0;
    rad_n      = rad_q;
    rem_n      = rem_q;
    root_n     = root_q;
    shifted    = '0;
    diff       = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      single_res[l*BIT_WIDTH +: BIT_WIDTH] =
        lane_op(bus.fn, bus.data_in0[l*BIT_WIDTH +: BIT_WIDTH], bus.data_in1[l*BIT_WIDTH +: BIT_WIDTH]);
      shifted  = {rem_q[l][H-1:0], rad_q[l][BIT_WIDTH-1 -: 2]};
      diff     = {1'b0, shifted} - {1'b0, root_q[l], 2'b01};
      rad_n[l] = rad_q[l] << 2;
      if (!diff[H+2]) begin
        rem_n[l]  = diff[H+1:0];
        root_n[l] = {root_q[l][H-2:0], 1'b1};
      end else begin
        rem_n[l]  = shifted;
        root_n[l] = {root_q[l][H-2:0], 1'b0};
      end
      sqrt_res[l*BIT_WIDTH +: BIT_WIDTH] = {{(BIT_WIDTH-H){1'b0}}, root_n[l]};
    end
  end

  always_comb begin
    logic [BIT_WIDTH-1:0] a;
    state_d = state_q;
    cnt_d   = cnt_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    dout_d  = dout_q;
    a       = '0;
    case (state_q)
      CALC: begin
        rad_d  = rad_n;
        rem_d  = rem_n;
        root_d = root_n;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(H - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          dout_d  = sqrt_res;
        end
      end
      DONE: begin
        if (bus.out_ready && !accept) state_d = IDLE;
      end
      default: ;
    endcase
    // accept is only possible from IDLE or from a draining DONE
    if (accept) begin
      if (bus.fn == FN_SQRT) begin
        state_d = CALC;
        cnt_d   = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
          a         = bus.data_in0[l*BIT_WIDTH +: BIT_WIDTH];
          rad_d[l]  = (!a[BIT_WIDTH-1] && (a != '0)) ? a : '0;
          rem_d[l]  = '0;
          root_d[l] = '0;
        end
      end else begin
        state_d = DONE;
        dout_d  = single_res;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rad_q   <= '{default: '0};
      rem_q   <= '{default: '0};
      root_q  <= '{default: '0};
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == CALC);
  assign bus.data_out  = dout_q;

endmodule

// File: tb/tb_calculus_unit_pipe.sv
// Scoreboard bench for calculus_unit_pipe: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every output handshake.
module tb_calculus_unit_pipe;

  localparam int FB = 4;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int DW = L * W;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;
  logic [DW-1:0] exp_q [$];

  calculus_unit_pipe_if #(.FUNCTION_BITS(FB), .BIT_WIDTH(W), .LANES(L)) bus ();

  calculus_unit_pipe #(.FUNCTION_BITS(FB), .BIT_WIDTH(W), .LANES(L)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pk(input logic [W-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h expected none", bus.data_out);
      end else begin
        chk("result", bus.data_out, exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [FB-1:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] exp, output int waits);
    bus.fn       = f;
    bus.data_in0 = a;
    bus.data_in1 = b;
    bus.in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
    end else begin
      exp_q.push_back(exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic single(input string name, input logic [FB-1:0] f, input logic [DW-1:0] a,
                        input logic [DW-1:0] b, input logic [DW-1:0] exp);
    int w;
    send(f, a, b, exp, w);
    idle();
    @(negedge clk);
    chk(name, 128'(bus.out_valid), 128'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic sqrt_run(input logic [DW-1:0] a, input logic [DW-1:0] exp);
    int w;
    int n;
    logic flags_ok;
    send(4'b1000, a, '0, exp, w);
    idle();
    n = 0;
    flags_ok = 1'b1;
    @(negedge clk);
    while (!bus.out_valid && n < 40) begin
      if (!bus.busy || bus.in_ready) flags_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("sqrt_latency", 128'(n), 128'(16));
    chk("calc_busy_noready", 128'(flags_ok), 128'(1));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w;
    int wsum;
    int c0;
    int t;
    logic [DW-1:0] held;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.fn = '0;
    bus.in_valid = 1'b0;
    bus.data_in0 = '0;
    bus.data_in1 = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 128'(bus.out_valid), 128'(0));
    chk("reset_data_out", bus.data_out, '0);
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_in_ready", 128'(bus.in_ready), 128'(1));
    reset = 1'b0;
    @(posedge clk);
    #1;

    single("relu_lat", 4'b0000, pk(5, -7, 0, -1), '0, pk(5, 0, 0, 0));
    single("sign_lat", 4'b0011, pk(5, -7, 0, -1), '0, pk(1, -1, 0, -1));
    single("max_lat", 4'b0001, pk(5, -7, 0, -1), pk(6, -8, 0, 3), pk(6, -7, 0, 3));
    single("abs_lat", 4'b0010, pk(32'h80000000, -3, 3, 0), '0, pk(32'h7FFFFFFF, 3, 3, 0));
    single("rsvd_lat", 4'b0101, pk(5, -7, 9, 1), pk(2, 2, 2, 2), '0);

    sqrt_run(pk(1000000, 32'h7FFFFFFF, 0, -4), pk(1000, 46340, 0, 0));
    sqrt_run(pk(1, 3, 4, 15), pk(1, 1, 2, 3));

    // Backpressure: first result held while a second transaction waits upstream
    bus.out_ready = 1'b0;
    send(4'b0000, pk(11, 22, -33, 44), '0, pk(11, 22, 0, 44), w);
    bus.fn = 4'b0000;
    bus.data_in0 = pk(-1, 2, 3, -4);
    bus.in_valid = 1'b1;
    held = pk(11, 22, 0, 44);
    repeat (5) begin
      @(negedge clk);
      chk("hold_out_valid", 128'(bus.out_valid), 128'(1));
      chk("hold_data_out", bus.data_out, held);
      chk("hold_in_ready", 128'(bus.in_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(4'b0000, pk(-1, 2, 3, -4), '0, pk(0, 2, 3, 0), w);
    chk("release_no_bubble", 128'(w), 128'(0));

    wsum = 0;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      send(4'b0000, pk(i + 1, -i, 3 * i, -1), '0, pk(i + 1, 0, 3 * i, 0), w);
      wsum += w;
    end
    chk("burst_cycles", 128'(cyc - c0), 128'(8));
    chk("burst_waits", 128'(wsum), 128'(0));
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Reset during SQRT: the pending result must never appear
    send(4'b1000, pk(1000000, 81, 16, 9), '0, pk(1000, 9, 4, 3), w);
    idle();
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    chk("midrst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("midrst_data_out", bus.data_out, '0);
    chk("midrst_busy", 128'(bus.busy), 128'(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    single("post_rst_relu", 4'b0000, pk(-9, 9, 100, -100), '0, pk(0, 9, 100, 0));

    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk("drain", 128'(exp_q.size()), 128'(0));
    repeat (20) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
